// File: rtl/mult_div_unit_if.sv
// =============================================================================
// mult_div_unit_if : EX-stage <-> multiply/divide unit operand and result bus
// Revision: 1.0
// =============================================================================
`default_nettype none

interface mult_div_unit_if;
  logic        op_valid;
  logic [2:0]  md_op;
  logic [31:0] rs_out;
  logic [31:0] rt_out;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output op_valid, md_op, rs_out, rt_out,
    input  busy, stall_req, hi_out, lo_out
  );

  modport slave (
    input  op_valid, md_op, rs_out, rt_out,
    output busy, stall_req, hi_out, lo_out
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// =============================================================================
// mult_div_unit : multi-cycle mult/multu/div/divu plus HI/LO register file
// Revision: 1.0
// =============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  wire               clk,
  input  wire               reset,
  mult_div_unit_if.slave    md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    op_q,    op_d;
  logic [31:0]   a_q,     a_d;
  logic [31:0]   b_q,     b_d;
  logic [31:0]   hi_q,    hi_d;
  logic [31:0]   lo_q,    lo_d;

  logic          w_start_op;
  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [31:0]   w_a_mag;
  logic [31:0]   w_b_mag;
  logic [31:0]   w_den_u;
  logic [31:0]   w_den_s;
  logic [31:0]   w_q_mag;
  logic [31:0]   w_r_mag;
  logic [31:0]   w_quo_s;
  logic [31:0]   w_rem_s;
  logic [31:0]   w_quo_u;
  logic [31:0]   w_rem_u;

  assign w_start_op = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);

  // Result datapath works purely from the latched operands.
  assign w_prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign w_prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly.
  // A zero divisor is replaced by 1 to keep the dividers X-free; the
  // result is discarded in that case anyway.
  assign w_a_neg = a_q[31];
  assign w_b_neg = b_q[31];
  assign w_a_mag = w_a_neg ? (32'd0 - a_q) : a_q;
  assign w_b_mag = w_b_neg ? (32'd0 - b_q) : b_q;
  assign w_den_s = (b_q == 32'd0) ? 32'd1 : w_b_mag;
  assign w_den_u = (b_q == 32'd0) ? 32'd1 : b_q;
  assign w_q_mag = w_a_mag / w_den_s;
  assign w_r_mag = w_a_mag % w_den_s;
  assign w_quo_s = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem_s = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_quo_u = a_q / w_den_u;
  assign w_rem_u = a_q % w_den_u;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (md.op_valid) begin
          if (w_start_op) begin
            state_d = S_RUN;
            op_d    = md.md_op;
            a_d     = md.rs_out;
            b_d     = md.rt_out;
            cnt_d   = (md.md_op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          end else if (md.md_op == OP_MTHI) begin
            hi_d = md.rs_out;
          end else if (md.md_op == OP_MTLO) begin
            lo_d = md.rs_out;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT: begin
              hi_d = w_prod_s[63:32];
              lo_d = w_prod_s[31:0];
            end
            OP_MULTU: begin
              hi_d = w_prod_u[63:32];
              lo_d = w_prod_u[31:0];
            end
            OP_DIV: begin
              if (b_q != 32'd0) begin
                hi_d = w_rem_s;
                lo_d = w_quo_s;
              end
            end
            OP_DIVU: begin
              if (b_q != 32'd0) begin
                hi_d = w_rem_u;
                lo_d = w_quo_u;
              end
            end
            default: begin
            end
          endcase
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    md.busy      = (state_q == S_RUN);
    md.stall_req = (state_q == S_RUN) || (md.op_valid && w_start_op);
    md.hi_out    = hi_q;
    md.lo_out    = lo_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// =============================================================================
// tb_mult_div_unit : vector table, corner sequences and random ops vs a model
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_div_unit_if bus ();

  mult_div_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Present one op for one cycle, then count the busy cycles that follow.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int n, output logic st);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.md_op    = op;
    bus.rs_out   = rs;
    bus.rt_out   = rt;
    #1;
    st = bus.stall_req;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd0;
    bus.rs_out   = 32'd0;
    bus.rt_out   = 32'd0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  // Architectural reference: HI/LO after one op, using wide plain arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    cyc = 0;
    case (op)
      3'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; cyc = 5; end
      3'd2: begin p = 64'(a) * 64'(b); hi = p[63:32]; lo = p[31:0]; cyc = 5; end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); lo = p[31:0];
          p = 64'(sr); hi = p[31:0];
        end
      end
      3'd4: begin
        cyc = 10;
        if (b != 0) begin hi = a % b; lo = a / b; end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: begin end
    endcase
  endtask

  vec_t        vt[12];
  int          n;
  logic        st;
  logic [31:0] m_hi, m_lo;
  int          m_cyc;
  logic [2:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    checks = 0;
    errors = 0;
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd0;
    bus.rs_out   = 32'd0;
    bus.rt_out   = 32'd0;
    reset = 1'b1;

    vt[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vt[1]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vt[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[3]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
    vt[4]  = '{3'd5, 32'h00000011, 32'h00000000, 32'h00000011, 32'h7FFFFFFC, 0};
    vt[5]  = '{3'd6, 32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 0};
    vt[6]  = '{3'd3, 32'h00001234, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vt[7]  = '{3'd4, 32'hDEADBEEF, 32'h00000000, 32'h00000011, 32'h00000022, 10};
    vt[8]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vt[9]  = '{3'd0, 32'h12345678, 32'h00000001, 32'h00000000, 32'h80000000, 0};
    vt[10] = '{3'd7, 32'h12345678, 32'h00000001, 32'h00000000, 32'h80000000, 0};
    vt[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_busy",  {31'd0, bus.busy},      32'd0);
    chk("reset_stall", {31'd0, bus.stall_req}, 32'd0);
    chk("reset_hi",    bus.hi_out,             32'd0);
    chk("reset_lo",    bus.lo_out,             32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].op, vt[i].rs, vt[i].rt, n, st);
      chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(vt[i].cyc));
      chk($sformatf("vec%0d_stall", i), {31'd0, st},
          {31'd0, (vt[i].op >= 3'd1 && vt[i].op <= 3'd4)});
      chk($sformatf("vec%0d_hi", i), bus.hi_out, vt[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo_out, vt[i].lo);
    end

    // Ops presented mid-run must be dropped while stall_req holds.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.md_op = 3'd1; bus.rs_out = 32'd3; bus.rt_out = 32'd4;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0; bus.md_op = 3'd0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.op_valid = 1'b0; bus.md_op = 3'd0; bus.rs_out = 32'd0; bus.rt_out = 32'd0;
      if (c == 2) begin bus.op_valid = 1'b1; bus.md_op = 3'd6; bus.rs_out = 32'h55; end
      if (c == 3) begin
        bus.op_valid = 1'b1; bus.md_op = 3'd1; bus.rs_out = 32'd7; bus.rt_out = 32'd9;
      end
      #1;
      chk($sformatf("ignore_busy_c%0d", c), {31'd0, bus.busy}, {31'd0, (c <= 5)});
      if (c <= 5) chk($sformatf("ignore_stall_c%0d", c), {31'd0, bus.stall_req}, 32'd1);
    end
    bus.op_valid = 1'b0; bus.md_op = 3'd0;
    chk("ignore_hi", bus.hi_out, 32'd0);
    chk("ignore_lo", bus.lo_out, 32'd12);

    // Reset in the middle of a divide aborts it without a write.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.md_op = 3'd3; bus.rs_out = 32'd100; bus.rt_out = 32'd7;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0; bus.md_op = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi",   bus.hi_out,        32'd0);
    chk("abort_lo",   bus.lo_out,        32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_late_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_late_lo",   bus.lo_out,        32'd0);
    run_op(3'd2, 32'h00010000, 32'h00010003, n, st);
    chk("post_reset_cycles", 32'(n), 32'd5);
    chk("post_reset_hi", bus.hi_out, 32'h00000001);
    chk("post_reset_lo", bus.lo_out, 32'h00030000);

    // Random ops against the reference model.
    m_hi = bus.hi_out;
    m_lo = bus.lo_out;
    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, m_hi, m_lo, m_cyc);
      run_op(rop, ra, rb, n, st);
      chk($sformatf("rnd%0d_op%0d_cycles", k, rop), 32'(n), 32'(m_cyc));
      chk($sformatf("rnd%0d_op%0d_hi", k, rop), bus.hi_out, m_hi);
      chk($sformatf("rnd%0d_op%0d_lo", k, rop), bus.lo_out, m_lo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
